cdc_hndshk_src_ctrl: RTL

- Source-domain front end that feeds the toggle-based CDC handshake stage.
- Accepts data words over a valid/ready interface and buffers them in a small synchronous FIFO.
- Launches one crossing per word: holds the word stable on hold_data, flips a request toggle and waits for the returned acknowledge toggle before launching the next word.
- Detects a stalled far side with a cycle timeout and reports it as a sticky error.

---
 rtl/cdc_hndshk_pkg.sv | 17 +
 rtl/cdc_hndshk_fifo.sv | 51 +++++
 rtl/cdc_hndshk_src_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/cdc_hndshk_pkg.sv
// Shared types and width helpers for the source side of the toggle CDC handshake.
package cdc_hndshk_pkg;

  typedef enum logic {
    SRC_IDLE = 1'b0,
    SRC_WAIT = 1'b1
  } src_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdc_hndshk_fifo.sv
// Small synchronous FIFO with registered pointers; read data is the head entry, no bypass.
module cdc_hndshk_fifo
  import cdc_hndshk_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = ptr_w(FIFO_DEPTH),
  localparam int LW        = lvl_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LW-1:0]     level_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              do_push, do_pop;

  assign full_o     = (level_q == LW'(FIFO_DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/cdc_hndshk_src_ctrl.sv
// Source-domain launcher: buffers words, crosses them one at a time with a request toggle,
// waits for the acknowledge toggle and flags stalls or spurious acks as a sticky error.
module cdc_hndshk_src_ctrl
  import cdc_hndshk_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        source_clk,
  input  logic                        source_reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [DATA_W-1:0]           hold_data,
  output logic                        req_toggle,
  output logic                        req_pulse,
  input  logic                        ack_toggle,
  output logic                        busy,
  output logic                        done_pulse,
  output logic                        err_timeout,
  input  logic                        err_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  src_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, fifo_data;
  logic              req_q, req_d, req_pulse_q, req_pulse_d;
  logic              done_q, done_d, err_q, err_d, phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fifo_pop, fifo_full, fifo_empty, ack_ev, err_set;

  cdc_hndshk_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (source_clk),
    .rst_n      (source_reset_n),
    .push_i     (in_valid),
    .push_data_i(in_data),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign in_ready    = !fifo_full;
  assign busy        = (state_q == SRC_WAIT);
  assign hold_data   = hold_q;
  assign req_toggle  = req_q;
  assign req_pulse   = req_pulse_q;
  assign done_pulse  = done_q;
  assign err_timeout = err_q;
  assign ack_ev      = (ack_toggle != phase_q);
  assign fifo_pop    = (state_q == SRC_IDLE) && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    req_d       = req_q;
    req_pulse_d = 1'b0;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    err_set     = 1'b0;
    // ack_phase only ever moves to follow ack_toggle, so it can track it every cycle.
    phase_d     = ack_toggle;
    case (state_q)
      SRC_IDLE: begin
        if (ack_ev) err_set = 1'b1;
        if (fifo_pop) begin
          hold_d      = fifo_data;
          req_d       = ~req_q;
          req_pulse_d = 1'b1;
          cnt_d       = '0;
          state_d     = SRC_WAIT;
        end
      end
      SRC_WAIT: begin
        // The error fires on the step into saturation only, so err_clr sticks during a long stall.
        if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q != CNT_MAX)  cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) err_set = 1'b1;
        end
        if (ack_ev) begin
          done_d  = 1'b1;
          state_d = SRC_IDLE;
        end
      end
      default: state_d = SRC_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge source_clk or negedge source_reset_n) begin
    if (!source_reset_n) begin
      state_q     <= SRC_IDLE;
      hold_q      <= '0;
      req_q       <= 1'b0;
      req_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      req_q       <= req_d;
      req_pulse_q <= req_pulse_d;
      done_q      <= done_d;
      err_q       <= err_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
